piso_dir_tx: RTL
================

Name: piso_dir_tx

Overview:
- Parallel-in, serial-out transmitter with selectable shift direction. It is the sending end for the team's bidirectional serial shift receivers.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then drives it one bit per enabled clock on dout.
- Bit order is MSB-first or LSB-first, chosen per word. Framing strobes (sof, done) let the far-end shift register know where a word starts and ends.

Parameters:
- WIDTH, 4, word length in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_valid  input  1  producer has a word on pdata/l.
- load_ready  output  1  block can accept a word this cycle.
- pdata  input  WIDTH  parallel word to transmit.
- l  input  1  direction for the word being loaded:
  - 0 = MSB-first (data moves toward the high index at the receiver).
  - 1 = LSB-first.
- shift_en  input  1  advance to next bit on this edge; low = hold current bit.
- dout  output  1  serial data bit.
- dout_valid  output  1  dout carries a frame bit.
- sof  output  1  high while dout carries the first bit of a frame.
- busy  output  1  frame in progress (state SHIFT).
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset (reset=0, async): state=IDLE, shift reg=0, counter=0, dir reg=0.
  - Outputs: load_ready=1, dout=0, dout_valid=0, sof=0, busy=0, done=0.
  - Reset asserted mid-frame aborts the frame immediately. No done pulse is issued, and the remaining bits are discarded.
- All outputs are registered, except load_ready, which is decoded from state: load_ready = (state==IDLE).
- State IDLE:
  - load_ready=1, dout_valid=0, dout=0.
  - A load_valid=1 on a posedge accepts the word: latch pdata into the shift reg, latch l into the dir reg, counter=0, go to SHIFT.
  - On the same edge: dout <= pdata[WIDTH-1] if l=0, else pdata[0]; dout_valid<=1; sof<=1; busy<=1.
  - Latency: first bit is valid the cycle after the accept edge.
- State SHIFT:
  - load_valid is ignored and load_ready=0. Changes on pdata or l have no effect until the next IDLE accept.
  - shift_en=0: dout, dout_valid, sof and the counter hold.
  - shift_en=1 and counter<WIDTH-1:
    - counter+1, sof<=0.
    - Shift reg moves left (dir=0) or right (dir=1), zero-filled.
    - dout <= next bit, i.e. the new MSB (dir=0) or new LSB (dir=1).
  - shift_en=1 and counter==WIDTH-1 (last bit consumed):
    - dout<=0, dout_valid<=0, sof<=0, busy<=0, done<=1, go to IDLE.
- done is high for exactly one cycle after the final consumed bit.
  - A new word may be accepted in that same done-high cycle, since load_ready=1 in IDLE.
  - The next frame's first bit then appears one cycle after that accept, so there is a 1-cycle dout_valid gap between back-to-back frames.
- Bit count: exactly WIDTH bits per frame. Each bit is presented until a shift_en edge consumes it; each bit is held at least one cycle.
- sof and done are never high in the same cycle.
- Counter arithmetic is unsigned, CNT_W bits. It never wraps within a frame, because the terminal compare is WIDTH-1.
- Accept edge with shift_en=1: shift_en is ignored on the accept edge. The first bit is always presented for at least one cycle.
- No X propagation: dout is 0 whenever dout_valid=0.

Test Plan:
- Reset then idle: hold reset=0 for 3 clocks, release; load_valid=0 -> load_ready=1, dout=0, dout_valid=0, busy=0, done=0 throughout.
- MSB-first (WIDTH=4): load pdata=4'b1011, l=0, shift_en=1 continuously -> dout = 1,0,1,1 on 4 consecutive cycles after the accept edge; sof only on the first; done pulse on the 5th cycle; load_ready=1 again.
- LSB-first: pdata=4'b1011, l=1 -> dout = 1,1,0,1. A receiver shifting right with l=1 holds 4'b1011 after 4 bits.
- Stall: pdata=4'b0110, l=0; shift_en pattern 1,0,0,1,1,1 -> dout = 0 held 1 cycle, 1 held 3 cycles, then 1,0. The counter does not advance while shift_en=0, and done fires only after the 4th consumed bit.
- Ignore mid-frame changes: during a frame, toggle l and drive load_valid=1 with pdata=4'b1111 -> load_ready=0 and the current frame is unaltered. That word is accepted in the done cycle, and its first bit appears 1 cycle later.
- Async reset mid-frame: assert reset between clock edges after the 2nd bit -> dout, dout_valid, busy drop to 0 immediately without waiting for clk; no done pulse; load_ready=1 after release.

Source files
------------

// File: rtl/piso_dir_tx.sv
// Parallel-in, serial-out transmitter with a per-word shift direction.
// A word is loaded through a valid/ready handshake, then sent one bit per shift_en, framed by sof and done.
module piso_dir_tx #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pdata,
  input  logic             l,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0]       IDLE  = 1'b0;
  localparam logic [0:0]       SHIFT = 1'b1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             dir_reg;

  // dir_reg=0 sends MSB-first (shift left), dir_reg=1 sends LSB-first (shift right).
  always_comb begin
    shift_next = dir_reg ? (shift_reg >> 1) : (shift_reg << 1);
  end

  assign load_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_reg == IDLE) begin
        // shift_en is ignored on the accept edge so the first bit is always held a cycle.
        if (load_valid) begin
          shift_reg  <= pdata;
          dir_reg    <= l;
          cnt_reg    <= '0;
          state_reg  <= SHIFT;
          dout       <= l ? pdata[0] : pdata[WIDTH-1];
          dout_valid <= 1'b1;
          sof        <= 1'b1;
          busy       <= 1'b1;
        end
      end else if (shift_en) begin
        if (cnt_reg == LAST) begin
          state_reg  <= IDLE;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          sof        <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end else begin
          cnt_reg   <= cnt_reg + 1'b1;
          sof       <= 1'b0;
          shift_reg <= shift_next;
          dout      <= dir_reg ? shift_next[0] : shift_next[WIDTH-1];
        end
      end
    end
  end

endmodule
